cdb_flash_ctrl: RTL and testbench

- Parametrised parallel NOR flash bus engine for the CDB board; replaces the fixed tie-offs on the flash control pins.
- Executes single read, single write, burst read and wait-for-ready operations on the shared address/data bus.
- Drives the 16-bit bidirectional databus through the SB_IO tristate buffers via databus_o, databus_oe and databus_i.
- Higher-level command sequences (unlock, program, erase) are issued by the host as write/poll ops.

---
 rtl/cdb_flash_ctrl_if.sv | 28 ++
 rtl/cdb_flash_ctrl.sv | 156 +++++++++++++++
 tb/tb_cdb_flash_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_flash_ctrl_if.sv
// Host-side command/response handshake of the CDB parallel NOR flash engine.
// The host drives the command fields and the engine returns the response pulse.
interface cdb_flash_ctrl_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [LEN_W-1:0]  cmd_len;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );
endinterface

// File: rtl/cdb_flash_ctrl.sv
// Parallel NOR flash bus engine: single read/write, burst read and ready polling
// on the shared address/data bus, with every pin driven from a register.
module cdb_flash_ctrl #(
    parameter int ADDR_W        = 26,
    parameter int DATA_W        = 16,
    parameter int LEN_W         = 8,
    parameter int T_SETUP       = 1,
    parameter int T_PULSE       = 2,
    parameter int T_HOLD        = 1,
    parameter int READY_BLANK   = 4,
    parameter int READY_TIMEOUT = 65535
) (
    input  logic               clk_12mhz,
    input  logic               rst,
    cdb_flash_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]  a,
    output logic [DATA_W-1:0]  databus_o,
    output logic               databus_oe,
    input  logic [DATA_W-1:0]  databus_i,
    output logic               flash_nce,
    output logic               flash_noe,
    output logic               flash_nwe,
    input  logic               flash_ready
);
    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (T_HOLD > READY_TIMEOUT) ? T_HOLD : READY_TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_BURST = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [1:0]         op_reg;
    logic [LEN_W-1:0]   left_reg;
    logic [DATA_W-1:0]  cap_reg;
    logic [1:0]         rdy_sync_reg;
    logic               rdy_s;

    assign rdy_s = rdy_sync_reg[1];

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            op_reg          <= OP_READ;
            left_reg        <= '0;
            cap_reg         <= '0;
            rdy_sync_reg    <= '0;
            a               <= '0;
            databus_o       <= '0;
            databus_oe      <= 1'b0;
            flash_nce       <= 1'b1;
            flash_noe       <= 1'b1;
            flash_nwe       <= 1'b1;
            bus.cmd_ready   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            rdy_sync_reg  <= {rdy_sync_reg[0], flash_ready};
            bus.rsp_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_reg        <= bus.cmd_op;
                        left_reg      <= bus.cmd_len;
                        a             <= bus.cmd_addr;
                        cnt_reg       <= CNT_W'(1);
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_op == OP_WAIT) begin
                            state_reg <= S_WAIT;
                        end else begin
                            state_reg <= S_SETUP;
                            flash_nce <= 1'b0;
                            if (bus.cmd_op == OP_WRITE) begin
                                databus_o  <= bus.cmd_wdata;
                                databus_oe <= 1'b1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_reg == CNT_W'(T_SETUP)) begin
                        state_reg <= S_PULSE;
                        cnt_reg   <= CNT_W'(1);
                        if (op_reg == OP_WRITE) flash_nwe <= 1'b0;
                        else                    flash_noe <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    // Sample on the last strobe cycle so the flash has had the full pulse width.
                    if (cnt_reg == CNT_W'(T_PULSE)) begin
                        cap_reg   <= databus_i;
                        flash_noe <= 1'b1;
                        flash_nwe <= 1'b1;
                        state_reg <= S_HOLD;
                        cnt_reg   <= CNT_W'(1);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_reg == CNT_W'(T_HOLD)) begin
                        cnt_reg         <= CNT_W'(1);
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        if (op_reg != OP_WRITE) bus.rsp_rdata <= cap_reg;
                        if (op_reg == OP_BURST && left_reg != '0) begin
                            // Next burst word: nCE stays low, address wraps naturally.
                            left_reg  <= left_reg - LEN_W'(1);
                            a         <= a + ADDR_W'(1);
                            state_reg <= S_SETUP;
                        end else begin
                            state_reg     <= S_IDLE;
                            flash_nce     <= 1'b1;
                            databus_oe    <= 1'b0;
                            bus.cmd_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (cnt_reg > CNT_W'(READY_BLANK) && rdy_s) begin
                        state_reg       <= S_IDLE;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.cmd_ready   <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else if (cnt_reg == CNT_W'(READY_TIMEOUT)) begin
                        state_reg       <= S_IDLE;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.cmd_ready   <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cdb_flash_ctrl.sv
// Scoreboard bench for cdb_flash_ctrl: default timing with a short ready timeout
// on one instance and stretched strobe timing on a second instance.
module tb_cdb_flash_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        tmo;
        int          lo;
        int          hi;
    } exp_t;

    exp_t q_a[$];
    exp_t q_c[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- instance A: default strobes, READY_TIMEOUT=20 ----------------
    logic        rst_a;
    logic [25:0] a_a;
    logic [15:0] dbo_a, dbi_a;
    logic        dboe_a, nce_a, noe_a, nwe_a, ready_a;
    logic        burst_mode = 1'b0;

    cdb_flash_ctrl_if #(.ADDR_W(26), .DATA_W(16), .LEN_W(8)) bus_a();

    cdb_flash_ctrl #(.READY_BLANK(4), .READY_TIMEOUT(20)) dut_a (
        .clk_12mhz  (clk),
        .rst        (rst_a),
        .bus        (bus_a),
        .a          (a_a),
        .databus_o  (dbo_a),
        .databus_oe (dboe_a),
        .databus_i  (dbi_a),
        .flash_nce  (nce_a),
        .flash_noe  (noe_a),
        .flash_nwe  (nwe_a),
        .flash_ready(ready_a)
    );

    assign dbi_a = (noe_a == 1'b0) ? (burst_mode ? a_a[15:0] : 16'hBEEF) : 16'h0000;

    // ---------------- instance C: T_SETUP=3, T_PULSE=5, T_HOLD=2 ----------------
    logic        rst_c;
    logic [25:0] a_c;
    logic [15:0] dbo_c, dbi_c;
    logic        dboe_c, nce_c, noe_c, nwe_c;

    cdb_flash_ctrl_if #(.ADDR_W(26), .DATA_W(16), .LEN_W(8)) bus_c();

    cdb_flash_ctrl #(.T_SETUP(3), .T_PULSE(5), .T_HOLD(2)) dut_c (
        .clk_12mhz  (clk),
        .rst        (rst_c),
        .bus        (bus_c),
        .a          (a_c),
        .databus_o  (dbo_c),
        .databus_oe (dboe_c),
        .databus_i  (dbi_c),
        .flash_nce  (nce_c),
        .flash_noe  (noe_c),
        .flash_nwe  (nwe_c),
        .flash_ready(1'b1)
    );

    assign dbi_c = (noe_c == 1'b0) ? 16'hC0DE : 16'h0000;

    // ---------------- response monitors ----------------
    always @(negedge clk) begin
        if (bus_a.rsp_valid === 1'b1) begin
            exp_t e;
            $display("rsp A cyc=%0d rdata=%h tmo=%b", cyc, bus_a.rsp_rdata, bus_a.rsp_timeout);
            if (q_a.size() == 0) begin
                check("a_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_rsp_rdata", 32'(bus_a.rsp_rdata), 32'(e.rdata));
                check("a_rsp_timeout", 32'(bus_a.rsp_timeout), 32'(e.tmo));
                if (e.lo == e.hi) check("a_rsp_cycle", cyc, e.lo);
                else check("a_rsp_cycle_in_window", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_c.rsp_valid === 1'b1) begin
            exp_t e;
            $display("rsp C cyc=%0d rdata=%h tmo=%b", cyc, bus_c.rsp_rdata, bus_c.rsp_timeout);
            if (q_c.size() == 0) begin
                check("c_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q_c.pop_front();
                check("c_rsp_rdata", 32'(bus_c.rsp_rdata), 32'(e.rdata));
                check("c_rsp_timeout", 32'(bus_c.rsp_timeout), 32'(e.tmo));
                check("c_rsp_cycle", cyc, e.lo);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic issue_a(input logic [1:0] op, input logic [25:0] addr,
                           input logic [15:0] wdata, input logic [7:0] len, output int c0);
        int guard = 0;
        @(negedge clk);
        while (bus_a.cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("a_issue_ready", 32'(bus_a.cmd_ready), 32'd1);
        bus_a.cmd_op    = op;
        bus_a.cmd_addr  = addr;
        bus_a.cmd_wdata = wdata;
        bus_a.cmd_len   = len;
        bus_a.cmd_valid = 1'b1;
        c0 = cyc;
        $display("cmd A op=%0d addr=%h wdata=%h len=%0d cyc=%0d", op, addr, wdata, len, c0);
        @(posedge clk);
        #1 bus_a.cmd_valid = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] rdata, input logic tmo, input int lo, input int hi);
        exp_t e;
        e.rdata = rdata; e.tmo = tmo; e.lo = lo; e.hi = hi;
        q_a.push_back(e);
    endtask

    task automatic drain_a();
        int guard = 0;
        while (q_a.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("a_drain_left", q_a.size(), 32'd0);
    endtask

    task automatic drain_c();
        int guard = 0;
        while (q_c.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("c_drain_left", q_c.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        exp_t e;
        rst_a = 1'b1; rst_c = 1'b1; ready_a = 1'b0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 2'b00; bus_a.cmd_addr = '0;
        bus_a.cmd_wdata = '0;   bus_a.cmd_len = '0;
        bus_c.cmd_valid = 1'b0; bus_c.cmd_op = 2'b00; bus_c.cmd_addr = '0;
        bus_c.cmd_wdata = '0;   bus_c.cmd_len = '0;

        repeat (3) @(negedge clk);
        check("rst_a", 32'(a_a), 32'd0);
        check("rst_databus_o", 32'(dbo_a), 32'd0);
        check("rst_oe", 32'(dboe_a), 32'd0);
        check("rst_nce", 32'(nce_a), 32'd1);
        check("rst_noe", 32'(noe_a), 32'd1);
        check("rst_nwe", 32'(nwe_a), 32'd1);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        check("rst_rsp_timeout", 32'(bus_a.rsp_timeout), 32'd0);
        check("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        rst_a = 1'b0; rst_c = 1'b0;

        // Single READ
        burst_mode = 1'b0;
        issue_a(2'b00, 26'h1234567, 16'h0000, 8'd0, c0);
        push_a(16'hBEEF, 1'b0, c0 + 5, c0 + 5);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("rd_nce", 32'(nce_a), 32'(n > 4));
            check("rd_noe", 32'(noe_a), 32'(!(n == 2 || n == 3)));
            check("rd_oe", 32'(dboe_a), 32'd0);
            if (n <= 4) check("rd_addr", 32'(a_a), 32'h1234567);
        end
        drain_a();

        // Single WRITE
        issue_a(2'b01, 26'h555, 16'h00AA, 8'd0, c0);
        push_a(16'hBEEF, 1'b0, c0 + 5, c0 + 5);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("wr_oe", 32'(dboe_a), 32'(n <= 4));
            check("wr_nwe", 32'(nwe_a), 32'(!(n == 2 || n == 3)));
            check("wr_noe", 32'(noe_a), 32'd1);
            if (n <= 4) check("wr_dout", 32'(dbo_a), 32'h00AA);
        end
        drain_a();

        // READ_BURST across the address wrap
        burst_mode = 1'b1;
        issue_a(2'b11, 26'h3FFFFFE, 16'h0000, 8'd3, c0);
        push_a(16'hFFFE, 1'b0, c0 + 5,  c0 + 5);
        push_a(16'hFFFF, 1'b0, c0 + 9,  c0 + 9);
        push_a(16'h0000, 1'b0, c0 + 13, c0 + 13);
        push_a(16'h0001, 1'b0, c0 + 17, c0 + 17);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            check("bu_nce", 32'(nce_a), 32'(n > 16));
            if ((n % 4) == 1 && n <= 13)
                check("bu_addr", 32'(a_a), 32'((27'h3FFFFFE + 27'((n - 1) / 4)) & 27'h3FFFFFF));
        end
        drain_a();
        burst_mode = 1'b0;

        // WAIT_READY, ready rising in cycle 8
        ready_a = 1'b0;
        issue_a(2'b10, 26'h0, 16'h0000, 8'd0, c0);
        push_a(16'h0001, 1'b0, c0 + 10, c0 + 11);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 8) ready_a = 1'b1;
            check("wt_nce_idle", 32'(nce_a), 32'd1);
        end
        drain_a();
        ready_a = 1'b0;
        repeat (3) @(negedge clk);

        // WAIT_READY timeout
        issue_a(2'b10, 26'h0, 16'h0000, 8'd0, c0);
        push_a(16'h0001, 1'b1, c0 + 21, c0 + 21);
        drain_a();

        // Reset in cycle 2 of a WRITE
        issue_a(2'b01, 26'h100, 16'h1234, 8'd0, c0);
        @(posedge clk);
        #1;
        check("rs_pre_nwe", 32'(nwe_a), 32'd0);
        rst_a = 1'b1;
        #1;
        check("rs_nwe", 32'(nwe_a), 32'd1);
        check("rs_oe", 32'(dboe_a), 32'd0);
        check("rs_nce", 32'(nce_a), 32'd1);
        check("rs_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
        check("rs_busy", 32'(bus_a.busy), 32'd0);
        check("rs_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (6) @(negedge clk);

        // Fresh READ after reset
        issue_a(2'b00, 26'h42, 16'h0000, 8'd0, c0);
        push_a(16'hBEEF, 1'b0, c0 + 5, c0 + 5);
        drain_a();

        // Instance C: cmd_valid held high across back-to-back READs
        @(negedge clk);
        check("c_ready0", 32'(bus_c.cmd_ready), 32'd1);
        bus_c.cmd_op = 2'b00;
        bus_c.cmd_addr = 26'h77;
        bus_c.cmd_valid = 1'b1;
        c0 = cyc;
        $display("cmd C op=0 addr=%h cyc=%0d (valid held)", 26'h77, c0);
        e.rdata = 16'hC0DE; e.tmo = 1'b0; e.lo = c0 + 11; e.hi = c0 + 11;
        q_c.push_back(e);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            check("c_cmd_ready", 32'(bus_c.cmd_ready), 32'(n == 11));
            check("c_noe", 32'(noe_c), 32'(!(n >= 4 && n <= 8)));
        end
        e.lo = c0 + 22; e.hi = c0 + 22;
        q_c.push_back(e);
        @(posedge clk);
        #1 bus_c.cmd_valid = 1'b0;
        drain_c();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
